// File: rtl/reg_file_2r1w_pkg.sv
// Shared definitions for the 2-read/1-write register file.
package reg_file_2r1w_pkg;

    // Every storage and output flop clears to all-zero; replicate this bit to the needed width.
    localparam logic RegRstBit = 1'b0;

    // Select/address width for a power-of-two count; never narrower than one bit.
    function automatic int unsigned addr_width(int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/reg_file_2r1w_mux.sv
// N:1 combinational selector over a flattened N*WIDTH input bus.
module mux_param
    import reg_file_2r1w_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 16,
    localparam int unsigned SelW = addr_width(N)
) (
    input  logic [N*WIDTH-1:0] in_i,
    input  logic [SelW-1:0]    sel_i,
    output logic [WIDTH-1:0]   out_o
);

    // Pick slice sel_i out of the flattened bus.
    always_comb begin
        out_o = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (sel_i == SelW'(k)) begin
                out_o = in_i[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// DEPTH x WIDTH register file: one synchronous write port, two registered read ports
// with write-first forwarding. Register 0 can be hardwired to zero.
module reg_file_2r1w
    import reg_file_2r1w_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 16,
    parameter bit          ZERO_R0 = 1'b1,
    localparam int unsigned ADDR_W = addr_width(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_a_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    input  logic              re_b_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [WIDTH-1:0]  rdata_a_o,
    output logic [WIDTH-1:0]  rdata_b_o,
    output logic              rvalid_a_o,
    output logic              rvalid_b_o
);

    localparam logic [WIDTH-1:0] RstVal = {WIDTH{RegRstBit}};

    logic [DEPTH*WIDTH-1:0] regs_flat;
    logic [WIDTH-1:0]       mux_a, mux_b;
    logic                   wr_eff, fwd_a, fwd_b;
    logic [WIDTH-1:0]       rdata_a_d, rdata_a_q, rdata_b_d, rdata_b_q;
    logic                   rvalid_a_q, rvalid_b_q;

    // Storage; with ZERO_R0 register 0 has no flop and reads as constant zero.
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (ZERO_R0 && i == 0) begin : g_zero
            assign regs_flat[WIDTH-1:0] = RstVal;
        end else begin : g_flop
            logic [WIDTH-1:0] reg_q;

            // Register update: reset clears, write enable loads wdata.
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    reg_q <= RstVal;
                end else if (we_i && waddr_i == ADDR_W'(i)) begin
                    reg_q <= wdata_i;
                end
            end

            assign regs_flat[i*WIDTH +: WIDTH] = reg_q;
        end
    end

    mux_param #(
        .WIDTH (WIDTH),
        .N     (DEPTH)
    ) u_mux_a (
        .in_i  (regs_flat),
        .sel_i (raddr_a_i),
        .out_o (mux_a)
    );

    mux_param #(
        .WIDTH (WIDTH),
        .N     (DEPTH)
    ) u_mux_b (
        .in_i  (regs_flat),
        .sel_i (raddr_b_i),
        .out_o (mux_b)
    );

    // A write to a hardwired-zero r0 never lands, so it must not be forwarded either.
    assign wr_eff = we_i && !(ZERO_R0 && waddr_i == '0);
    assign fwd_a  = wr_eff && (waddr_i == raddr_a_i);
    assign fwd_b  = wr_eff && (waddr_i == raddr_b_i);

    // Next read data: write-first on address match, hold when the port is idle.
    always_comb begin
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        if (re_a_i) begin
            rdata_a_d = fwd_a ? wdata_i : mux_a;
        end
        if (re_b_i) begin
            rdata_b_d = fwd_b ? wdata_i : mux_b;
        end
    end

    // Output registers; reset discards any read issued in the same cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rdata_a_q  <= RstVal;
            rdata_b_q  <= RstVal;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            rvalid_a_q <= re_a_i;
            rvalid_b_q <= re_b_i;
        end
    end

    assign rdata_a_o  = rdata_a_q;
    assign rdata_b_o  = rdata_b_q;
    assign rvalid_a_o = rvalid_a_q;
    assign rvalid_b_o = rvalid_b_q;

endmodule
